// File: rtl/lenet_pkg.sv
// Types and constants shared by the LeNet feature-map stages.
package lenet_pkg;

   localparam int unsigned DATA_W = 8;

   typedef enum logic [1:0] {
      BankEmpty,
      BankFilling,
      BankReady
   } bank_st_e;

   typedef enum logic {
      WrFill,
      WrStall
   } wr_st_e;

endpackage

// File: rtl/fmap_bank.sv
// One feature-map bank: N x DATA_W RAM (one write port, one registered read port),
// a per-address valid bitmap and a count of distinct addresses written since the last clear.
module fmap_bank #(
   parameter int unsigned N      = 196,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_hit,
   output logic [ADDR_W:0]   fill_cnt,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam logic [ADDR_W:0] NumPix = (ADDR_W+1)'(N);

   logic [DATA_W-1:0] mem_q [N];
   logic [N-1:0]      bitmap_q, bitmap_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              wr_ok;
   logic              rd_ok;

   assign wr_ok    = wr_en && ({1'b0, wr_addr} < NumPix);
   assign rd_ok    = {1'b0, rd_addr} < NumPix;
   // Address already written this frame: a rewrite replaces data but must not bump the count.
   assign wr_hit   = wr_ok && bitmap_q[wr_addr];
   assign fill_cnt = cnt_q;
   assign rd_data  = rd_data_q;

   // Bitmap/counter bookkeeping and registered read; clear wins over a write.
   always_comb begin
      bitmap_d  = bitmap_q;
      cnt_d     = cnt_q;
      rd_data_d = rd_data_q;
      if (clr) begin
         bitmap_d = '0;
         cnt_d    = '0;
      end else if (wr_ok && !bitmap_q[wr_addr]) begin
         bitmap_d[wr_addr] = 1'b1;
         cnt_d             = cnt_q + (ADDR_W+1)'(1);
      end
      if (rd_en) begin
         rd_data_d = rd_ok ? mem_q[rd_addr] : '0;
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         bitmap_q  <= '0;
         cnt_q     <= '0;
         rd_data_q <= '0;
      end else begin
         bitmap_q  <= bitmap_d;
         cnt_q     <= cnt_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Pixel storage, deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

endmodule

// File: rtl/pool_fmap_buffer.sv
// Ping-pong feature-map buffer: fills one bank out of order while the other is read.
module pool_fmap_buffer #(
   parameter int unsigned OUT_W  = 14,
   parameter int unsigned OUT_H  = 14,
   parameter int unsigned DATA_W = lenet_pkg::DATA_W,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic [ADDR_W-1:0] in_addr,
   output logic              frame_ready,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   input  logic              frame_release,
   output logic              overflow,
   output logic              addr_err,
   output logic [7:0]        frame_count
);

   import lenet_pkg::*;

   localparam int unsigned     N       = OUT_W * OUT_H;
   localparam logic [ADDR_W:0] NumPix  = (ADDR_W+1)'(N);
   localparam logic [ADDR_W:0] LastCnt = (ADDR_W+1)'(N - 1);

   bank_st_e bank_st_q [2];
   bank_st_e bank_st_d [2];
   wr_st_e   wr_st_q, wr_st_d;
   logic     wr_sel_q, wr_sel_d;
   logic     rd_sel_q, rd_sel_d;
   logic     last_rd_q, last_rd_d;
   logic     frame_ready_q, frame_ready_d;
   logic     overflow_q, overflow_d;
   logic     addr_err_q, addr_err_d;
   logic [7:0] frame_count_q, frame_count_d;

   logic [1:0]        bank_wr_en;
   logic [1:0]        bank_clr;
   logic [1:0]        bank_rd_en;
   logic [1:0]        bank_hit;
   logic [ADDR_W:0]   bank_cnt [2];
   logic [DATA_W-1:0] bank_rd_data [2];

   logic addr_ok;
   logic release_ok;
   logic other_sel;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fmap_bank #(
         .N      (N),
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_bank (
         .clk      (clk),
         .rst      (rst),
         .clr      (bank_clr[b]),
         .wr_en    (bank_wr_en[b]),
         .wr_addr  (in_addr),
         .wr_data  (in_data),
         .wr_hit   (bank_hit[b]),
         .fill_cnt (bank_cnt[b]),
         .rd_en    (bank_rd_en[b]),
         .rd_addr  (rd_addr),
         .rd_data  (bank_rd_data[b])
      );
   end

   assign addr_ok     = {1'b0, in_addr} < NumPix;
   assign release_ok  = frame_release && frame_ready_q;
   assign other_sel   = ~wr_sel_q;
   assign frame_ready = frame_ready_q;
   assign overflow    = overflow_q;
   assign addr_err    = addr_err_q;
   assign frame_count = frame_count_q;
   // Read data stays with the bank last read so it holds across bank swaps.
   assign rd_data     = bank_rd_data[last_rd_q];

   // Write FSM, bank hand-over and read steering; a release is applied before completion.
   always_comb begin
      bank_st_d     = bank_st_q;
      wr_st_d       = wr_st_q;
      wr_sel_d      = wr_sel_q;
      rd_sel_d      = rd_sel_q;
      last_rd_d     = last_rd_q;
      overflow_d    = overflow_q;
      addr_err_d    = addr_err_q;
      frame_count_d = frame_count_q;
      bank_wr_en    = '0;
      bank_clr      = '0;
      bank_rd_en    = '0;

      if (in_valid && !addr_ok) begin
         addr_err_d = 1'b1;
      end

      if (release_ok) begin
         bank_st_d[rd_sel_q] = BankEmpty;
         bank_clr[rd_sel_q]  = 1'b1;
         rd_sel_d            = ~rd_sel_q;
      end

      unique case (wr_st_q)
         WrFill: begin
            if (in_valid && addr_ok) begin
               bank_wr_en[wr_sel_q] = 1'b1;
               if (!bank_hit[wr_sel_q] && (bank_cnt[wr_sel_q] == LastCnt)) begin
                  bank_st_d[wr_sel_q] = BankReady;
                  frame_count_d       = frame_count_q + 8'd1;
                  if (bank_st_d[other_sel] == BankEmpty) begin
                     bank_st_d[other_sel] = BankFilling;
                     wr_sel_d             = other_sel;
                  end else begin
                     wr_st_d = WrStall;
                  end
               end
            end
         end
         WrStall: begin
            // Pixels are dropped here, including the one in the cycle the stall ends.
            if (in_valid) begin
               overflow_d = 1'b1;
            end
            if (bank_st_d[other_sel] == BankEmpty) begin
               bank_st_d[other_sel] = BankFilling;
               wr_sel_d             = other_sel;
               wr_st_d              = WrFill;
            end
         end
         default: wr_st_d = WrFill;
      endcase

      // Forced low for one cycle after a release even if the other bank is already READY.
      frame_ready_d = (bank_st_d[rd_sel_d] == BankReady) && !release_ok;

      if (rd_en && frame_ready_q) begin
         bank_rd_en[rd_sel_q] = 1'b1;
         last_rd_d            = rd_sel_q;
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         bank_st_q[0]  <= BankFilling;
         bank_st_q[1]  <= BankEmpty;
         wr_st_q       <= WrFill;
         wr_sel_q      <= 1'b0;
         rd_sel_q      <= 1'b0;
         last_rd_q     <= 1'b0;
         frame_ready_q <= 1'b0;
         overflow_q    <= 1'b0;
         addr_err_q    <= 1'b0;
         frame_count_q <= 8'd0;
      end else begin
         bank_st_q     <= bank_st_d;
         wr_st_q       <= wr_st_d;
         wr_sel_q      <= wr_sel_d;
         rd_sel_q      <= rd_sel_d;
         last_rd_q     <= last_rd_d;
         frame_ready_q <= frame_ready_d;
         overflow_q    <= overflow_d;
         addr_err_q    <= addr_err_d;
         frame_count_q <= frame_count_d;
      end
   end

endmodule

// File: tb/tb_pool_fmap_buffer.sv
// Bench for pool_fmap_buffer: directed scenarios plus a random phase, checked every cycle
// against a frame-queue model of the buffer.
module tb_pool_fmap_buffer;

   localparam int NPIX = 196;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic [7:0] in_addr = 8'd0;
   logic       frame_ready;
   logic       rd_en = 1'b0;
   logic [7:0] rd_addr = 8'd0;
   logic [7:0] rd_data;
   logic       frame_release = 1'b0;
   logic       overflow;
   logic       addr_err;
   logic [7:0] frame_count;

   pool_fmap_buffer #(
      .OUT_W  (14),
      .OUT_H  (14),
      .DATA_W (8),
      .ADDR_W (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_addr       (in_addr),
      .frame_ready   (frame_ready),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .frame_release (frame_release),
      .overflow      (overflow),
      .addr_err      (addr_err),
      .frame_count   (frame_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: the frame being assembled plus a FIFO of completed frames (at most two
   // frames exist at once: two ready, or one ready and one filling).
   logic [7:0] cur [NPIX];
   bit         seen [NPIX];
   int         nseen;
   logic [7:0] rdy [2][NPIX];
   int         head;
   int         cnt;
   bit         stalled;
   bit         m_fr;
   bit         m_ovf;
   bit         m_aerr;
   logic [7:0] m_fc;
   logic [7:0] m_rd;
   int         perm [NPIX];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      assert (obs === exp) begin
         n_pass = n_pass + 1;
      end else begin
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NPIX; i++) seen[i] = 1'b0;
      nseen   = 0;
      head    = 0;
      cnt     = 0;
      stalled = 1'b0;
      m_fr    = 1'b0;
      m_ovf   = 1'b0;
      m_aerr  = 1'b0;
      m_fc    = 8'd0;
      m_rd    = 8'd0;
   endfunction

   function automatic void model_step();
      bit rel;
      if (rst) begin
         model_reset();
         return;
      end
      rel = frame_release && m_fr;
      if (rd_en && m_fr) m_rd = (int'(rd_addr) < NPIX) ? rdy[head][rd_addr] : 8'd0;
      if (rel) begin
         head = head ^ 1;
         cnt  = cnt - 1;
      end
      if (in_valid && int'(in_addr) >= NPIX) m_aerr = 1'b1;
      if (stalled) begin
         if (in_valid) m_ovf = 1'b1;
         if (cnt < 2) stalled = 1'b0;
      end else if (in_valid && int'(in_addr) < NPIX) begin
         cur[in_addr] = in_data;
         if (!seen[in_addr]) begin
            seen[in_addr] = 1'b1;
            nseen = nseen + 1;
         end
         if (nseen == NPIX) begin
            for (int i = 0; i < NPIX; i++) begin
               rdy[(head + cnt) % 2][i] = cur[i];
               seen[i] = 1'b0;
            end
            cnt   = cnt + 1;
            m_fc  = m_fc + 8'd1;
            nseen = 0;
            if (cnt == 2) stalled = 1'b1;
         end
      end
      m_fr = (cnt > 0) && !rel;
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check("frame_ready", {31'd0, frame_ready}, {31'd0, m_fr});
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      check("addr_err", {31'd0, addr_err}, {31'd0, m_aerr});
      check("frame_count", {24'd0, frame_count}, {24'd0, m_fc});
      check("rd_data", {24'd0, rd_data}, {24'd0, m_rd});
      in_valid      = 1'b0;
      rd_en         = 1'b0;
      frame_release = 1'b0;
   endtask

   task automatic pix(input int a, input logic [7:0] d);
      in_valid = 1'b1;
      in_addr  = 8'(a);
      in_data  = d;
      cycle();
   endtask

   task automatic shuffle();
      int j;
      int t;
      for (int i = 0; i < NPIX; i++) perm[i] = i;
      for (int i = NPIX - 1; i > 0; i--) begin
         j = int'($urandom_range(i, 0));
         t = perm[i];
         perm[i] = perm[j];
         perm[j] = t;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      int walk;
      model_reset();

      // Reset state.
      do_reset();
      check("reset_frame_ready", {31'd0, frame_ready}, 32'd0);
      check("reset_rd_data", {24'd0, rd_data}, 32'd0);

      // In-order frame, value = address.
      for (int a = 0; a < NPIX; a++) pix(a, 8'(a));
      check("A_ready", {31'd0, frame_ready}, 32'd1);
      check("A_count", {24'd0, frame_count}, 32'd1);
      rd_en = 1'b1; rd_addr = 8'd37; cycle();
      check("A_rd37", {24'd0, rd_data}, 32'd37);
      rd_en = 1'b1; rd_addr = 8'd200; cycle();
      check("rd_out_of_range", {24'd0, rd_data}, 32'd0);
      rd_addr = 8'd50; cycle();
      check("rd_hold_no_en", {24'd0, rd_data}, 32'd0);

      // Second frame with a duplicate and a bad address, then overflow.
      for (int a = 0; a < NPIX - 1; a++) begin
         pix(a, 8'($urandom));
         if (a == 100) pix(200, 8'($urandom));
      end
      check("B_addr_err", {31'd0, addr_err}, 32'd1);
      pix(10, 8'hAA);
      check("B_dup_no_complete", {24'd0, frame_count}, 32'd1);
      pix(NPIX - 1, 8'($urandom));
      check("B_count", {24'd0, frame_count}, 32'd2);
      check("B_no_overflow_yet", {31'd0, overflow}, 32'd0);
      for (int k = 0; k < 5; k++) pix(int'($urandom_range(NPIX - 1, 0)), 8'($urandom));
      check("stall_overflow", {31'd0, overflow}, 32'd1);
      check("stall_count", {24'd0, frame_count}, 32'd2);
      for (int k = 0; k < 6; k++) begin
         rd_en = 1'b1; rd_addr = 8'($urandom_range(NPIX - 1, 0)); cycle();
      end
      frame_release = 1'b1; cycle();
      check("release_drop", {31'd0, frame_ready}, 32'd0);
      cycle();
      check("release_rise", {31'd0, frame_ready}, 32'd1);
      pix(5, 8'h5A);
      rd_en = 1'b1; rd_addr = 8'd10; cycle();
      check("B_rd10_dup", {24'd0, rd_data}, 32'hAA);

      // Release on the exact cycle of the second frame's last write.
      do_reset();
      shuffle();
      for (int i = 0; i < NPIX; i++) pix(perm[i], 8'($urandom));
      shuffle();
      for (int i = 0; i < NPIX - 1; i++) pix(perm[i], 8'($urandom));
      frame_release = 1'b1;
      pix(perm[NPIX - 1], 8'($urandom));
      check("sim_no_overflow", {31'd0, overflow}, 32'd0);
      check("sim_gap", {31'd0, frame_ready}, 32'd0);
      check("sim_count", {24'd0, frame_count}, 32'd2);
      cycle();
      check("sim_bank1_ready", {31'd0, frame_ready}, 32'd1);
      pix(7, 8'h77);
      shuffle();
      for (int i = 0; i < NPIX; i++) if (perm[i] != 7) pix(perm[i], 8'($urandom));
      check("C_count", {24'd0, frame_count}, 32'd3);
      frame_release = 1'b1; cycle();
      cycle();
      rd_en = 1'b1; rd_addr = 8'd7; cycle();
      check("C_rd7", {24'd0, rd_data}, 32'h77);

      // Reset mid-frame discards the partial frame.
      do_reset();
      for (int k = 0; k < 100; k++) pix(k, 8'($urandom));
      do_reset();
      check("midrst_count", {24'd0, frame_count}, 32'd0);
      check("midrst_ready", {31'd0, frame_ready}, 32'd0);
      shuffle();
      for (int i = 0; i < NPIX; i++) pix(perm[i], 8'($urandom));
      check("midrst_refill", {24'd0, frame_count}, 32'd1);

      // Random traffic.
      do_reset();
      walk = 0;
      for (int k = 0; k < 3000; k++) begin
         in_valid      = ($urandom_range(9, 0) < 8);
         in_addr       = 8'(walk);
         in_data       = 8'($urandom);
         rd_en         = 1'($urandom_range(1, 0));
         rd_addr       = 8'($urandom_range(199, 0));
         frame_release = ($urandom_range(99, 0) < 4);
         if (in_valid) walk = (walk + int'($urandom_range(2, 0))) % 200;
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pool_fmap_buffer.md
# pool_fmap_buffer

Ping-pong feature-map buffer directly downstream of the conv/maxpool stage. Captures each pooled pixel (value plus linear address, qualified by the stage's data-ready strobe) into the active bank and tracks which addresses have been filled. A completed bank is handed to the next layer's read port while the other bank fills. Frames are assembled out of order; duplicates are tolerated.

## Interface
- OUT_W, 14, pooled map width
- OUT_H, 14, pooled map height
- DATA_W, 8, pixel width
- ADDR_W, 8, address width; must satisfy 2^ADDR_W >= OUT_W*OUT_H
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  pixel strobe from pooling stage
- in_data  in  DATA_W  pooled pixel
- in_addr  in  ADDR_W  linear index y*OUT_W+x, legal range 0..N-1 (N=OUT_W*OUT_H)
- frame_ready  out  1  a complete bank is available for reading
- rd_en  in  1  read request on ready bank
- rd_addr  in  ADDR_W  read index
- rd_data  out  DATA_W  registered read data
- frame_release  in  1  one-cycle pulse: consumer done with ready bank
- overflow  out  1  sticky: pixel dropped because no bank free
- addr_err  out  1  sticky: in_addr >= N seen
- frame_count  out  8  completed frames, wraps 255->0

## Operation
- Per bank: state EMPTY / FILLING / READY, N-bit valid bitmap, fill counter (ADDR_W+1 bits).
- Reset: bank0 FILLING, bank1 EMPTY, wr_sel=0, bitmaps/counters zero, all outputs 0. RAM contents not cleared.
- Write FSM states: FILL, STALL.
- FILL, in_valid, in_addr < N: write RAM[wr_sel][in_addr]. If bitmap bit clear: set it, counter+1. If set: overwrite data only, counter unchanged.
- in_addr >= N: no write, set addr_err; counter unchanged.
- Counter reaching N: bank -> READY, frame_count+1. If other bank EMPTY: it becomes FILLING, wr_sel toggles, stay FILL. Else -> STALL.
- STALL: all in_valid pixels dropped, each sets overflow. On other bank becoming EMPTY: it becomes FILLING, wr_sel toggles, -> FILL.
- Read side: rd_sel points at oldest READY bank. frame_ready = that bank READY.
- rd_en while frame_ready low: rd_data holds. rd_addr >= N: rd_data = 0.
- frame_release with frame_ready high: bank -> EMPTY, bitmap and counter cleared, rd_sel toggles. Ignored when frame_ready low.
- Simultaneous release and completion: release applied first; completing bank becomes READY and released bank becomes FILLING in the same cycle, no STALL entry, no drop.
- Release in the same cycle STALL exits: pixel that cycle dropped (overflow set); next cycle writes.
- Reset mid-frame: partial frame discarded, sticky flags cleared, frame_count zero.

## Timing
- Write: RAM and bitmap updated at the edge sampling in_valid.
- Completion: frame_ready rises the cycle after the N-th unique write.
- Read latency: 1 cycle, rd_data valid edge after rd_en.
- frame_ready falls the cycle after frame_release; next READY bank (if any) drives frame_ready high the following cycle.
- overflow/addr_err rise the cycle after the offending strobe, clear only on rst.
- Throughput: one pixel per cycle in FILL, no backpressure port.

## Structure
- Shared package lenet_pkg: DATA_W, bank-state enum (EMPTY/FILLING/READY), write-FSM enum (FILL/STALL).
- Sub-module fmap_bank: one-write-port, one-sync-read-port RAM of N x DATA_W plus valid bitmap with clear; instantiated twice.
- Top holds FSM, counters, bank select, sticky flags.

## Test plan
- Write addresses 0..195 in order, value = addr[7:0] -> frame_ready high 1 cycle after addr 195; rd_addr 37 returns 37 next cycle; frame_count = 1.
- Write 0..194, repeat addr 10 with 0xAA, then 195 -> completes only after 195; rd_addr 10 returns 0xAA.
- Fill two frames without release, then 5 more pixels -> overflow = 1, frame_count = 2; release -> frame_ready drops 1 cycle, rises again next cycle for bank1; next pixel written into bank0.
- in_addr = 200 once mid-frame -> addr_err = 1, frame not completed by it, all other data intact.
- Release on the exact cycle of the second frame's 196th write -> no overflow, bank1 READY, bank0 FILLING, next pixel accepted.
- rst asserted after 100 pixels -> all outputs 0 next cycle; 196 fresh writes complete a frame with frame_count = 1.
